// File: rtl/st_out_stage.sv
// st_out_stage: switch-traversal output stage of the mesh router.
// Steers the granted flit into one of NPORT small output FIFOs, tracks
// wormhole packet ownership per port and back-pressures the allocator.
module st_out_stage #(
  parameter int WIDTH = 32,
  parameter int NPORT = 5,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       SA_flit,
  input  logic [2:0]             SA_gate,
  output logic                   ST_stop,
  output logic [NPORT*WIDTH-1:0] OUT_flit,
  output logic [NPORT-1:0]       OUT_valid,
  input  logic [NPORT-1:0]       OUT_stop,
  output logic [NPORT-1:0]       port_busy,
  output logic                   err,
  output logic [CNTW-1:0]        flit_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  // Flit type decode: 00 idle, 01 head, 10 body, 11 tail
  logic [1:0] flit_type;
  logic       in_valid;
  logic       is_head;
  logic       is_tail;
  logic       is_cont;

  assign flit_type = SA_flit[WIDTH-1 -: 2];
  assign in_valid  = (flit_type != 2'b00);
  assign is_head   = (flit_type == 2'b01);
  assign is_tail   = (flit_type == 2'b11);
  assign is_cont   = flit_type[1];

  logic [NPORT-1:0] sel_hit;
  logic [NPORT-1:0] full_vec;
  logic [NPORT-1:0] push;
  logic [NPORT-1:0] pop;
  logic [NPORT-1:0] busy_reg;
  logic [NPORT-1:0] busy_next;
  logic             err_reg;
  logic [CNTW-1:0]  cnt_reg;
  logic             good_gate;
  logic             sel_busy;
  logic             sel_full;
  logic             accept;
  logic             drop_err;

  // Accept / drop / stall decision for the single presented flit.
  // A protocol error (bad gate, or body/tail to an idle port) always
  // consumes the flit, even when the target FIFO happens to be full.
  always_comb begin
    good_gate = |sel_hit;
    sel_busy  = |(sel_hit & busy_reg);
    sel_full  = |(sel_hit & full_vec);
    drop_err  = in_valid & (~good_gate | (is_cont & ~sel_busy));
    accept    = in_valid & good_gate & ~sel_full &
                ((is_head & ~sel_busy) | (is_cont & sel_busy));
    ST_stop   = in_valid & good_gate & ~accept & ~drop_err;
    push      = accept ? sel_hit : '0;
    busy_next = busy_reg;
    if (accept && is_head) busy_next = busy_reg | sel_hit;
    if (accept && is_tail) busy_next = busy_reg & ~sel_hit;
  end

  // Packet ownership, sticky error and accepted-flit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      if (drop_err) err_reg <= 1'b1;
      if (accept)   cnt_reg <= cnt_reg + CNTW'(1);
    end
  end

  assign port_busy = busy_reg;
  assign err       = err_reg;
  assign flit_cnt  = cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [AW-1:0]    rd_ptr_reg;
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW:0]      occ_reg;

      assign sel_hit[gi]   = (SA_gate == 3'(gi));
      assign full_vec[gi]  = (occ_reg == OCC_FULL);
      assign OUT_valid[gi] = (occ_reg != '0);
      assign pop[gi]       = OUT_valid[gi] & ~OUT_stop[gi];
      assign OUT_flit[gi*WIDTH +: WIDTH] = OUT_valid[gi] ? mem_reg[rd_ptr_reg] : '0;

      // Pointer and occupancy tracking; push and pop may coincide
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          occ_reg    <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          case ({push[gi], pop[gi]})
            2'b10:   occ_reg <= occ_reg + (AW+1)'(1);
            2'b01:   occ_reg <= occ_reg - (AW+1)'(1);
            default: occ_reg <= occ_reg;
          endcase
        end
      end

      // Flit storage; contents are masked by OUT_valid so no reset needed
      always_ff @(posedge clk) begin
        if (push[gi]) mem_reg[wr_ptr_reg] <= SA_flit;
      end
    end
  endgenerate

endmodule

// File: tb/tb_st_out_stage.sv
// tb_st_out_stage: directed plus random stimulus for st_out_stage,
// checked against a queue-based model of the output stage.
module tb_st_out_stage;
  localparam int W  = 32;
  localparam int NP = 5;
  localparam int D  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  SA_flit = '0;
  logic [2:0]    SA_gate = '0;
  logic          ST_stop;
  logic [NP*W-1:0] OUT_flit;
  logic [NP-1:0] OUT_valid;
  logic [NP-1:0] OUT_stop = '0;
  logic [NP-1:0] port_busy;
  logic          err;
  logic [CW-1:0] flit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one queue per output port plus packet/err/count tracking
  logic [W-1:0]  mq [NP][$];
  logic [NP-1:0] m_busy;
  logic          m_err;
  int unsigned   m_cnt;

  st_out_stage #(.WIDTH(W), .NPORT(NP), .DEPTH(D), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .SA_flit(SA_flit), .SA_gate(SA_gate),
    .ST_stop(ST_stop), .OUT_flit(OUT_flit), .OUT_valid(OUT_valid),
    .OUT_stop(OUT_stop), .port_busy(port_busy), .err(err), .flit_cnt(flit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NP*W-1:0] obs, input logic [NP*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < NP; k++) mq[k].delete();
    m_busy = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  // Rules: bad gate or body/tail to idle port is an error drop; otherwise
  // a head needs an idle port, body/tail need an open packet, and the
  // queue must have room. Anything else stalls.
  function automatic void m_eval(input logic [W-1:0] f, input logic [2:0] g,
                                 output logic acc, output logic stall, output logic bad);
    logic [1:0] t;
    t = f[W-1:W-2];
    acc = 1'b0; stall = 1'b0; bad = 1'b0;
    if (t != 2'b00) begin
      if (int'(g) >= NP) bad = 1'b1;
      else if (t != 2'b01 && !m_busy[g]) bad = 1'b1;
      else if (mq[g].size() < D && ((t == 2'b01) ? !m_busy[g] : m_busy[g])) acc = 1'b1;
      else stall = 1'b1;
    end
  endfunction

  task automatic check_state(input string tag);
    logic [NP*W-1:0] ef;
    logic [NP-1:0]   ev;
    ef = '0; ev = '0;
    for (int k = 0; k < NP; k++) begin
      if (mq[k].size() > 0) begin
        ev[k] = 1'b1;
        ef[k*W +: W] = mq[k][0];
      end
    end
    chk({tag, "/valid"}, OUT_valid, ev);
    chk({tag, "/flit"},  OUT_flit,  ef);
    chk({tag, "/busy"},  port_busy, m_busy);
    chk({tag, "/err"},   err,       m_err);
    chk({tag, "/cnt"},   flit_cnt,  CW'(m_cnt));
  endtask

  // One clock cycle: drive on negedge, check, then advance model at posedge
  task automatic step(input logic [W-1:0] f, input logic [2:0] g,
                      input logic [NP-1:0] stop, output logic acc);
    logic a, s, b;
    @(negedge clk);
    SA_flit = f; SA_gate = g; OUT_stop = stop;
    #1;
    m_eval(f, g, a, s, b);
    check_state("cycle");
    chk("st_stop", ST_stop, s);
    @(posedge clk);
    for (int k = 0; k < NP; k++)
      if (mq[k].size() > 0 && !stop[k]) void'(mq[k].pop_front());
    if (b) m_err = 1'b1;
    if (a) begin
      mq[g].push_back(f);
      m_cnt++;
      if (f[W-1:W-2] == 2'b01) m_busy[g] = 1'b1;
      if (f[W-1:W-2] == 2'b11) m_busy[g] = 1'b0;
    end
    acc = a;
  endtask

  // Async reset in the middle of a cycle, checked before any clock edge
  task automatic async_reset(input string tag);
    @(negedge clk);
    SA_flit = '0; SA_gate = '0;
    #2 reset = 1'b0;
    #1;
    m_reset();
    check_state(tag);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic a;
    logic [W-1:0] pf;
    logic [2:0]   pg;
    logic         pstall;
    int           saved_cnt;

    // Reset state
    m_reset();
    #1 reset = 1'b0;
    #1 check_state("reset");
    @(negedge clk) reset = 1'b1;

    // Single head to port 2, one-cycle latency
    step(32'h4000_00AA, 3'd2, 5'b00000, a);
    #1;
    chk("tp1_valid", OUT_valid, 5'b00100);
    chk("tp1_flit2", OUT_flit[2*W +: W], 32'h4000_00AA);
    chk("tp1_busy2", port_busy[2], 1'b1);
    chk("tp1_cnt", flit_cnt, 16'd1);

    // Head/body/tail through port 1
    step(32'h4000_0001, 3'd1, 5'b00000, a);
    #1 chk("tp2_h", OUT_flit[1*W +: W], 32'h4000_0001);
    step(32'h8000_0002, 3'd1, 5'b00000, a);
    #1 chk("tp2_b", OUT_flit[1*W +: W], 32'h8000_0002);
    step(32'hC000_0003, 3'd1, 5'b00000, a);
    #1 chk("tp2_t", OUT_flit[1*W +: W], 32'hC000_0003);
    chk("tp2_busy1", port_busy[1], 1'b0);
    chk("tp2_cnt", flit_cnt, 16'd4);

    // Full FIFO on port 3 stalls the third flit; full-before-pop honoured
    step(32'h4000_0010, 3'd3, 5'b01000, a);
    step(32'h8000_0011, 3'd3, 5'b01000, a);
    step(32'h8000_0012, 3'd3, 5'b01000, a);
    step(32'h8000_0012, 3'd3, 5'b00000, a);
    step(32'h8000_0012, 3'd3, 5'b00000, a);
    #1 chk("tp3_order", OUT_flit[3*W +: W], 32'h8000_0012);
    step(32'hC000_0013, 3'd3, 5'b00000, a);

    // Head to a busy port waits for the open packet's tail
    step(32'h4000_0020, 3'd0, 5'b00000, a);
    step(32'h4000_0021, 3'd0, 5'b00000, a);
    step(32'h4000_0021, 3'd0, 5'b00000, a);
    step(32'hC000_0022, 3'd0, 5'b00000, a);
    step(32'h4000_0021, 3'd0, 5'b00000, a);
    #1 chk("tp4_busy0", port_busy[0], 1'b1);
    chk("tp4_flit0", OUT_flit[0*W +: W], 32'h4000_0021);
    step(32'hC000_0023, 3'd0, 5'b00000, a);

    // Protocol errors: body to idle port, then bad gate
    #1 chk("tp5_err_before", err, 1'b0);
    saved_cnt = int'(flit_cnt);
    step(32'h8000_0005, 3'd4, 5'b00000, a);
    #1 chk("tp5_err", err, 1'b1);
    chk("tp5_cnt", flit_cnt, CW'(saved_cnt));
    step(32'h4000_0006, 3'd6, 5'b00000, a);
    #1 chk("tp5_err_sticky", err, 1'b1);
    chk("tp5_valid4", OUT_valid[4], 1'b0);

    // Buffered flits on ports 0 and 2, then asynchronous reset
    step(32'h4000_0030, 3'd0, 5'b00101, a);
    step(32'h8000_0031, 3'd2, 5'b00101, a);
    step(32'h0000_0000, 3'd0, 5'b00101, a);
    #1 chk("tp6_buffered", OUT_valid & 5'b00101, 5'b00101);
    async_reset("tp6_async");

    // Random traffic with allocator-style hold on stall
    pf = '0; pg = '0; pstall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] f;
      logic [2:0]   g;
      logic s, b, acc0;
      if (i == 300) async_reset("rand_async");
      if (pstall && $urandom_range(0, 9) < 7) begin
        f = pf; g = pg;
      end else begin
        f = $urandom();
        f[W-1:W-2] = 2'($urandom_range(0, 3));
        g = ($urandom_range(0, 19) < 19) ? 3'($urandom_range(0, NP-1)) : 3'($urandom_range(NP, 7));
      end
      m_eval(f, g, acc0, s, b);
      pstall = s; pf = f; pg = g;
      step(f, g, NP'($urandom_range(0, 31) & $urandom_range(0, 31)), a);
    end
    step('0, 3'd0, 5'b00000, a);
    step('0, 3'd0, 5'b00000, a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
